puf_ram_arbiter: RTL
====================

# puf_ram_arbiter

Arbiter and sequencer for the shared `combined_ram` PUF SRAM (8192 × 16-bit words). It shares the single read/write port pair between two requesters: port 0 is the readout path (UART dump FSM) and port 1 is the maintenance path (test-pattern writer or self-check). It registers all memory-side signals, tags read responses back to the issuing requester, and write-protects the SRAM after reset so the power-up PUF pattern cannot be destroyed before it has been read out.

## Interface
Parameters:
- `AW`, 13: word address width.
- `DW`, 16: data and write-mask width.

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`/`req1`  in  1  request; held high with a stable payload until the matching grant is seen.
- `we0`/`we1`  in  1  1 = write, 0 = read.
- `addr0`/`addr1`  in  AW  word address.
- `wdata0`/`wdata1`  in  DW  write data.
- `wmask0`/`wmask1`  in  DW  write mask, passed through unchanged.
- `lock0`/`lock1`  in  1  keep ownership after the current transfer (burst).
- `gnt0`/`gnt1`  out  1  combinational grant; the transfer is accepted when `reqN & gntN`.
- `rvalid0`/`rvalid1`  out  1  read data valid for that requester.
- `rdata`  out  DW  read data shared by both requesters; qualified by `rvalidN`.
- `wr_unlock`  in  1  pulse that enables SRAM writes.
- `wr_blocked`  out  1  one-cycle pulse when an accepted write is suppressed.
- `mem_raddr`, `mem_waddr`  out  AW  memory addresses.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`, `mem_wmask`  out  DW  memory write data and write mask.
- `mem_rdata`  in  DW  memory read data; valid one cycle after `mem_raddr`.

## Operation
- The arbiter state is one of IDLE, OWN0 or OWN1. Reset puts it in IDLE.
- In IDLE, if exactly one request is high, that requester is granted. If both are high, the priority rule in Configuration decides.
- When a request is accepted with its `lockN` high, the state moves to OWNN. In OWNN only requester N can be granted, and only on cycles where `reqN` is high.
- In OWNN, when an accepted transfer has `lockN` low, or `reqN` is low, the state returns to IDLE on the next edge.
- Accepted read: `mem_raddr` ← `addr` and the requester tag enters the response pipeline.
- Accepted write: `mem_waddr`, `mem_wdata` and `mem_wmask` are loaded from the requester. `mem_we` is set only if writes are unlocked. Otherwise `mem_we` stays 0 and `wr_blocked` pulses.
- When no transfer is accepted, `mem_we` is 0 and the address and data registers hold their values.
- Write unlock:
  - `wr_unlocked` resets to 0.
  - It is set by a `wr_unlock` pulse.
  - It is also set automatically when port 0 issues a read to address 2^AW−1, meaning the full readout has completed.
  - Once set, it stays set until reset.
- Response pipeline:
  - Two stages, each holding a valid bit and a one-bit tag.
  - `rvalidN` is driven from stage 2, and `rdata` = `mem_rdata`.
  - A requester never stalls a response; it must capture the data on `rvalid`.
- Address counters inside requesters wrap naturally. The arbiter performs no address arithmetic.

## Timing
- Reset values:
  - `gnt*` = 0 while `rst` is high.
  - `rvalid*` = 0.
  - `mem_we` = 0.
  - `mem_raddr`, `mem_waddr`, `mem_wdata`, `mem_wmask` = 0.
  - `wr_blocked` = 0.
  - State = IDLE; pipeline empty; round-robin pointer favours port 0.
- Accepted at edge T: the memory signals are valid in cycle T+1 and `rvalidN` is high in cycle T+2.
- For a write, the SRAM is updated at the edge ending cycle T+1.
- `wr_blocked` is high during cycle T+1.
- Throughput is one transfer per cycle, including back-to-back transfers from alternating requesters.
- A read and a write to the same address on consecutive cycles return the old data. No bypass is provided.
- Simultaneous `wr_unlock` and an accepted write in the same cycle: the write is still blocked. The unlock takes effect from the next acceptance.
- Reset asserted mid-operation drops in-flight responses. No `rvalid` appears after `rst`.

## Configuration
- `PUF_RAM_ARB_RR_EN` defined: round-robin arbitration.
  - After every accepted transfer from port N, the pointer favours the other port.
  - Ties in IDLE go to the favoured port.
- `PUF_RAM_ARB_RR_EN` undefined: fixed priority. Port 0 always wins ties in IDLE.
- Lock ownership behaves identically in both modes.

## Structure
- Shared package `puf_pkg` holds:
  - `PUF_AW` = 13, `PUF_DW` = 16, `PUF_WORDS` = 8192;
  - the arbiter state encoding (IDLE = 0, OWN0 = 1, OWN1 = 2);
  - the response tag type.
- Sub-module `puf_rsp_pipe`: the two-stage valid/tag pipeline with synchronous clear.
- The rest is a single module.

## Test plan
- Reset, then port 1 writes 0xA5A5 to address 5 with no unlock: `wr_blocked` pulses and a later read of address 5 returns the original power-up value.
- `wr_unlock` pulse, port 1 writes 0x1234 to address 7, port 0 reads address 7: `rvalid0` two cycles after the grant, with `rdata` = 0x1234.
- Both ports request reads continuously with round-robin enabled: grants alternate 0,1,0,1 and every `rvalid` carries the correct tag. With round-robin disabled, port 0 gets every grant.
- Port 1 holds `lock1` for 4 reads while port 0 also requests: port 0 receives no grant until after the 4th read, then is granted.
- Port 0 reads addresses 0..8191 with no `wr_unlock`: after the read of 8191, a port-1 write to address 0 succeeds with no `wr_blocked`.
- Assert `rst` one cycle after a read is accepted: no `rvalid` follows, and all outputs return to their reset values.

Source files
------------

// File: rtl/puf_pkg.sv
// puf_pkg: shared sizes, arbiter state encoding and response tag type for the PUF SRAM arbiter
package puf_pkg;
  localparam int PUF_AW = 13;
  localparam int PUF_DW = 16;
  localparam int PUF_WORDS = 8192;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_e;
  typedef logic rsp_tag_t;
endpackage

// File: rtl/puf_rsp_pipe.sv
// puf_rsp_pipe: two-stage valid/tag pipeline aligning read responses with the SRAM latency
// Ports: push_i/tag_i enter stage 1; valid_o/tag_o leave stage 2; rst clears both stages.
module puf_rsp_pipe
  import puf_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  rsp_tag_t tag_i,
  output logic     valid_o,
  output rsp_tag_t tag_o
);
  logic [1:0] v_q;
  rsp_tag_t t1_q, t2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
    end else begin
      v_q <= {v_q[0], push_i};
      t1_q <= tag_i;
      t2_q <= t1_q;
    end
  end
  assign valid_o = v_q[1];
  assign tag_o = t2_q;
endmodule

// File: rtl/puf_ram_arbiter.sv
// puf_ram_arbiter: shares the combined_ram PUF SRAM between readout (port 0) and maintenance (port 1)
// Ports: reqN/weN/addrN/wdataN/wmaskN/lockN requests, gntN combinational grants, rvalidN/rdata tagged
// responses, wr_unlock/wr_blocked write protection, mem_* registered SRAM port.
// Option: PUF_RAM_ARB_RR_EN selects round-robin tie breaking; default is fixed priority to port 0.
module puf_ram_arbiter
  import puf_pkg::*;
#(
  parameter int AW = PUF_AW,
  parameter int DW = PUF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wmask0,
  input  logic [DW-1:0] wmask1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  input  logic          wr_unlock,
  output logic          wr_blocked,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_wmask,
  input  logic [DW-1:0] mem_rdata
);
  arb_state_e state_q, state_d;
  logic unl_q, unl_d, we_q, blk_q, acc, sel, we_s, lk, pick1, rv;
  logic [AW-1:0] raddr_q, waddr_q, addr_s;
  logic [DW-1:0] wdata_q, wmask_q;
  rsp_tag_t rtag;
`ifdef PUF_RAM_ARB_RR_EN
  logic ptr_q;
  always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : (acc ? !sel : ptr_q);
  assign pick1 = ptr_q;
`else
  assign pick1 = 1'b0;
`endif
  // Ownership excludes the other port entirely; ties only matter in IDLE.
  assign gnt0 = !rst && req0 && (state_q == OWN0 || (state_q == IDLE && !(req1 && pick1)));
  assign gnt1 = !rst && req1 && (state_q == OWN1 || (state_q == IDLE && (!req0 || pick1)));
  assign acc = gnt0 || gnt1;
  assign sel = gnt1;
  assign we_s = sel ? we1 : we0;
  assign lk = sel ? lock1 : lock0;
  assign addr_s = sel ? addr1 : addr0;
  // Reading the last word on the readout port means the PUF dump is complete.
  assign unl_d = unl_q || wr_unlock || (gnt0 && !we0 && &addr0);
  always_comb begin
    state_d = IDLE;
    if (acc && lk) state_d = sel ? OWN1 : OWN0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      unl_q <= 1'b0;
      we_q <= 1'b0;
      blk_q <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      unl_q <= unl_d;
      we_q <= acc && we_s && unl_q;
      blk_q <= acc && we_s && !unl_q;
      if (acc && !we_s) raddr_q <= addr_s;
      if (acc && we_s) begin
        waddr_q <= addr_s;
        wdata_q <= sel ? wdata1 : wdata0;
        wmask_q <= sel ? wmask1 : wmask0;
      end
    end
  end
  puf_rsp_pipe u_pipe (
    .clk(clk),
    .rst(rst),
    .push_i(acc && !we_s),
    .tag_i(sel),
    .valid_o(rv),
    .tag_o(rtag)
  );
  assign rvalid0 = rv && !rtag;
  assign rvalid1 = rv && rtag;
  assign rdata = mem_rdata;
  assign mem_we = we_q;
  assign wr_blocked = blk_q;
  assign mem_raddr = raddr_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
endmodule
